fft_stream: RTL and testbench

Parametrised, streaming successor to the fixed 256-point array-port FFT in the audio-visualizer path. It accepts N real time-domain samples over a valid/ready stream and computes an in-place iterative radix-2 decimation-in-time FFT, one butterfly per clock, with 1/2 scaling per stage. It then streams N complex bins, scaled by 1/N, in natural order to the spectrum/bar-graph logic.

---
 rtl/fft_stream_if.sv | 28 ++
 rtl/fft_stream.sv | 201 ++++++++++++++++++++
 tb/tb_fft_stream.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_if.sv
// Stream bundle for fft_stream: sample input, bin output and status.
// Modport slave is the FFT block; master is the producer/consumer side.
interface fft_stream_if #(
    parameter int WIDTH = 12,
    parameter int DW    = WIDTH + 2,
    parameter int LOG2N = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_sample;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DW-1:0]    out_re;
    logic signed [DW-1:0]    out_im;
    logic [LOG2N-1:0]        out_index;
    logic                    out_last;
    logic                    busy;

    modport master (
        output in_valid, in_sample, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_last, busy
    );

    modport slave (
        input  in_valid, in_sample, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_last, busy
    );
endinterface

// File: rtl/fft_stream.sv
// Streaming in-place radix-2 DIT FFT, one butterfly per clock, 1/2 scaling per stage.
// Optional FFT_MAG_OUT_EN: output |re|+|im| (saturated) through one extra register stage.
module fft_stream #(
    parameter int N        = 256,
    parameter int WIDTH    = 12,
    parameter int TW_WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    fft_stream_if.slave bus
);
    localparam int LOG2N = $clog2(N);
    localparam int DW    = WIDTH + 2;
    localparam int DW1   = DW + 1;
    localparam int DW2   = DW + 2;
    localparam int HW    = LOG2N - 1;
    localparam int SW    = $clog2(LOG2N);
    localparam int PW    = DW + TW_WIDTH + 1;
    localparam int TWMAX = (1 << (TW_WIDTH - 1)) - 1;

    // Twiddles via Taylor series so the ROM folds at elaboration without libm.
    function automatic int tw_val(input int t, input bit is_sin);
        real th, x2, tc, ts, c, s, v;
        int  r;
        th = 2.0 * 3.14159265358979323846 * real'(t) / real'(N);
        x2 = th * th;
        tc = 1.0; ts = th; c = 1.0; s = th;
        for (int unsigned n = 1; n < 30; n++) begin
            tc = -tc * x2 / real'((2 * n - 1) * (2 * n));
            ts = -ts * x2 / real'((2 * n) * (2 * n + 1));
            c  = c + tc;
            s  = s + ts;
        end
        v = (is_sin ? s : c) * real'(1 << (TW_WIDTH - 1));
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        if (r > TWMAX) r = TWMAX;
        return is_sin ? -r : r;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int unsigned i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    logic signed [TW_WIDTH-1:0] tw_re [N/2];
    logic signed [TW_WIDTH-1:0] tw_im [N/2];

    for (genvar g = 0; g < N/2; g++) begin : g_tw
        localparam int WR = tw_val(g, 1'b0);
        localparam int WI = tw_val(g, 1'b1);
        assign tw_re[g] = TW_WIDTH'(WR);
        assign tw_im[g] = TW_WIDTH'(WI);
    end

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_PREP, S_UNLOAD} state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [HW-1:0]    j_q, j_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             load_we, bf_we;

    logic signed [DW-1:0] mem_re_q [N];
    logic signed [DW-1:0] mem_im_q [N];

    logic [LOG2N-1:0]     jx, mask, top, bot;
    logic [HW-1:0]        tidx;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im, nt_re, nt_im, nb_re, nb_im;
    logic signed [PW-1:0] m_re, m_im;
    logic signed [DW1-1:0] p_re, p_im;
    logic signed [DW2-1:0] s_re, s_im, d_re, d_im;

    always_comb begin
        jx   = {1'b0, j_q};
        mask = (LOG2N'(1) << stage_q) - LOG2N'(1);
        top  = (((jx >> stage_q) << stage_q) << 1) | (jx & mask);
        bot  = top | (LOG2N'(1) << stage_q);
        tidx = HW'((jx & mask) << (HW - int'(stage_q)));
        a_re = mem_re_q[top];
        a_im = mem_im_q[top];
        b_re = mem_re_q[bot];
        b_im = mem_im_q[bot];
        m_re = PW'(b_re) * PW'(tw_re[tidx]) - PW'(b_im) * PW'(tw_im[tidx]);
        m_im = PW'(b_re) * PW'(tw_im[tidx]) + PW'(b_im) * PW'(tw_re[tidx]);
        if (tidx == '0) begin
            p_re = DW1'(b_re);
            p_im = DW1'(b_im);
        end else begin
            p_re = DW1'(m_re >>> (TW_WIDTH - 1));
            p_im = DW1'(m_im >>> (TW_WIDTH - 1));
        end
        s_re  = DW2'(a_re) + DW2'(p_re);
        s_im  = DW2'(a_im) + DW2'(p_im);
        d_re  = DW2'(a_re) - DW2'(p_re);
        d_im  = DW2'(a_im) - DW2'(p_im);
        nt_re = DW'(s_re >>> 1);
        nt_im = DW'(s_im >>> 1);
        nb_re = DW'(d_re >>> 1);
        nb_im = DW'(d_im >>> 1);
    end

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_re_q[bitrev(cnt_q)] <= DW'(bus.in_sample);
            mem_im_q[bitrev(cnt_q)] <= '0;
        end else if (bf_we) begin
            mem_re_q[top] <= nt_re;
            mem_im_q[top] <= nt_im;
            mem_re_q[bot] <= nb_re;
            mem_im_q[bot] <= nb_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            j_q     <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        stage_d = stage_q;
        load_we = 1'b0;
        bf_we   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    load_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == '1) state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                bf_we = 1'b1;
                j_d   = j_q + 1'b1;
                if (j_q == '1) begin
                    if (stage_q == SW'(LOG2N - 1)) begin
                        stage_d = '0;
`ifdef FFT_MAG_OUT_EN
                        state_d = S_PREP;
`else
                        state_d = S_UNLOAD;
`endif
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            S_PREP: state_d = S_UNLOAD;
            S_UNLOAD: begin
                if (bus.out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.busy      = (state_q == S_COMPUTE);
    assign bus.out_valid = (state_q == S_UNLOAD);
    assign bus.out_last  = bus.out_valid && (cnt_q == '1);
    assign bus.out_index = bus.out_valid ? cnt_q : '0;

`ifdef FFT_MAG_OUT_EN
    // Magnitude register tracks the next bin index so it is ready on the cycle cnt_q advances.
    logic [DW-1:0]   mag_q, mag_d;
    logic [DW1-1:0]  abs_re, abs_im;
    logic [DW2-1:0]  mag_sum;

    always_comb begin
        abs_re  = mem_re_q[cnt_d][DW-1] ? DW1'(-DW1'(mem_re_q[cnt_d])) : DW1'(mem_re_q[cnt_d]);
        abs_im  = mem_im_q[cnt_d][DW-1] ? DW1'(-DW1'(mem_im_q[cnt_d])) : DW1'(mem_im_q[cnt_d]);
        mag_sum = DW2'(abs_re) + DW2'(abs_im);
        mag_d   = (mag_sum > DW2'((1 << (DW - 1)) - 1)) ? DW'((1 << (DW - 1)) - 1) : DW'(mag_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mag_q <= '0;
        else     mag_q <= mag_d;
    end

    assign bus.out_re = bus.out_valid ? mag_q : '0;
    assign bus.out_im = '0;
`else
    assign bus.out_re = bus.out_valid ? mem_re_q[cnt_q] : '0;
    assign bus.out_im = bus.out_valid ? mem_im_q[cnt_q] : '0;
`endif
endmodule

// File: tb/tb_fft_stream.sv
// Self-checking bench for fft_stream (N=8); directed frames plus random frames
// against an integer reference of the scaled radix-2 DIT algorithm.
module tb_fft_stream;
    localparam int N     = 8;
    localparam int WIDTH = 12;
    localparam int DW    = WIDTH + 2;
    localparam int LOG2N = 3;
    localparam int MAGMAX = (1 << (DW - 1)) - 1;

    typedef int frame_t [N];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_stream_if #(.WIDTH(WIDTH), .DW(DW), .LOG2N(LOG2N)) bus ();

    fft_stream #(.N(N), .WIDTH(WIDTH), .TW_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    int cap_re [N];
    int cap_im [N];
    int cap_idx [N];
    int cap_last [N];
    int cap_unstable, cap_overlap;
    bit cap_timeout;

    function automatic longint tw(input int t, input bit im_part);
        real    ang, v;
        longint r;
        ang = 6.283185307179586 * real'(t) / real'(N);
        v = (im_part ? $sin(ang) : $cos(ang)) * 32768.0;
        r = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
        if (r > 32767) r = 32767;
        return im_part ? -r : r;
    endfunction

    function automatic void model(input frame_t x, output frame_t er, output frame_t ei);
        longint re [N];
        longint im [N];
        for (int k = 0; k < N; k++) begin
            int rv = 0;
            for (int i = 0; i < LOG2N; i++) rv |= ((k >> i) & 1) << (LOG2N - 1 - i);
            re[rv] = x[k];
            im[rv] = 0;
        end
        for (int s = 0; s < LOG2N; s++) begin
            int half = 1 << s;
            for (int base = 0; base < N; base += 2 * half) begin
                for (int m = 0; m < half; m++) begin
                    int t = m * (N / (2 * half));
                    int a = base + m;
                    int b = a + half;
                    longint wr = tw(t, 1'b0);
                    longint wi = tw(t, 1'b1);
                    longint pr, pi, ar, ai;
                    if (t == 0) begin
                        pr = re[b];
                        pi = im[b];
                    end else begin
                        pr = (re[b] * wr - im[b] * wi) >>> 15;
                        pi = (re[b] * wi + im[b] * wr) >>> 15;
                    end
                    ar = re[a];
                    ai = im[a];
                    re[a] = (ar + pr) >>> 1;
                    im[a] = (ai + pi) >>> 1;
                    re[b] = (ar - pr) >>> 1;
                    im[b] = (ai - pi) >>> 1;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
`ifdef FFT_MAG_OUT_EN
            longint mg = (re[k] < 0 ? -re[k] : re[k]) + (im[k] < 0 ? -im[k] : im[k]);
            er[k] = int'(mg > MAGMAX ? MAGMAX : mg);
            ei[k] = 0;
`else
            er[k] = int'(re[k]);
            ei[k] = int'(im[k]);
`endif
        end
    endfunction

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input frame_t x, output bit timeout);
        timeout = 1'b0;
        for (int i = 0; i < N; i++) begin
            int g = 0;
            bus.in_valid  = 1'b1;
            bus.in_sample = WIDTH'(x[i]);
            while (!bus.in_ready && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (!bus.in_ready) timeout = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic count_busy(output int n, output bit valid_at_fall, output int nonzero);
        n = 0;
        nonzero = 0;
        while (bus.busy && n < 100) begin
            if (bus.out_re !== '0 || bus.out_im !== '0) nonzero++;
            @(negedge clk);
            n++;
        end
        valid_at_fall = bus.out_valid;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic collect(input int mode);
        int k = 0;
        int cyc = 0;
        int pat = 0;
        bit r, stalled;
        logic signed [DW-1:0] pre_re, pre_im;
        stalled = 1'b0;
        pre_re = '0;
        pre_im = '0;
        cap_unstable = 0;
        cap_overlap = 0;
        cap_timeout = 1'b0;
        while (k < N && cyc < 400) begin
            if (bus.in_ready && bus.out_valid) cap_overlap++;
            if (bus.busy && (bus.in_ready || bus.out_valid)) cap_overlap++;
            if (stalled && (bus.out_re !== pre_re || bus.out_im !== pre_im || int'(bus.out_index) != k))
                cap_unstable++;
            case (mode)
                0: r = 1'b1;
                1: r = (pat % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            pat++;
            bus.out_ready = r;
            if (bus.out_valid) begin
                cap_re[k]   = int'(bus.out_re);
                cap_im[k]   = int'(bus.out_im);
                cap_idx[k]  = int'(bus.out_index);
                cap_last[k] = int'(bus.out_last);
                if (r) begin
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pre_re = bus.out_re;
                    pre_im = bus.out_im;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (k < N) cap_timeout = 1'b1;
    endtask

    task automatic run_frame(input string name, input frame_t x, input frame_t er, input frame_t ei,
                             input int mode, input bit chk_busy);
        bit to, vf;
        int nb, nz;
        send_frame(x, to);
        tests++;
        if (to || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_after_load: timeout=%0b in_ready=%0b busy=%0b, want 0/0/1", name, to, bus.in_ready, bus.busy);
        end
        count_busy(nb, vf, nz);
        if (chk_busy) begin
            tests++;
            if (nb != 12) begin
                fails++;
                $display("FAIL %s_busy_len: got %0d cycles want 12", name, nb);
            end
            tests++;
            if (nz != 0) begin
                fails++;
                $display("FAIL %s_zero_while_invalid: %0d nonzero samples want 0", name, nz);
            end
`ifndef FFT_MAG_OUT_EN
            tests++;
            if (vf !== 1'b1) begin
                fails++;
                $display("FAIL %s_valid_at_busy_fall: got %0b want 1", name, vf);
            end
`endif
        end
        collect(mode);
        tests++;
        if (cap_timeout || cap_overlap != 0 || cap_unstable != 0) begin
            fails++;
            $display("FAIL %s_stream: timeout=%0b overlap=%0d unstable=%0d want 0/0/0", name, cap_timeout, cap_overlap, cap_unstable);
        end
        for (int k = 0; k < N; k++) begin
            tests++;
            if (cap_re[k] != er[k] || cap_im[k] != ei[k] || cap_idx[k] != k || cap_last[k] != int'(k == N - 1)) begin
                fails++;
                $display("FAIL %s_bin%0d: got re=%0d im=%0d idx=%0d last=%0d want re=%0d im=%0d idx=%0d last=%0d",
                         name, k, cap_re[k], cap_im[k], cap_idx[k], cap_last[k], er[k], ei[k], k, int'(k == N - 1));
            end
        end
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_return_load: in_ready=%0b out_valid=%0b want 1/0", name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.out_index !== '0 || bus.out_re !== '0 || bus.out_im !== '0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b busy=%0b last=%0b idx=%0d re=%0d im=%0d want 1/0/0/0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_last, bus.out_index, bus.out_re, bus.out_im);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        frame_t x = '{800, 0, 0, 0, 0, 0, 0, 0};
        frame_t er = '{100, 100, 100, 100, 100, 100, 100, 100};
        frame_t ei = '{default: 0};
        run_frame("impulse", x, er, ei, 0, 1'b1);
    endtask

    task automatic test_dc();
        frame_t x = '{default: 800};
        frame_t er = '{800, 0, 0, 0, 0, 0, 0, 0};
        frame_t ei = '{default: 0};
        run_frame("dc", x, er, ei, 0, 1'b1);
    endtask

    task automatic test_alternating();
        frame_t x = '{800, -800, 800, -800, 800, -800, 800, -800};
        frame_t er = '{0, 0, 0, 0, 800, 0, 0, 0};
        frame_t ei = '{default: 0};
        run_frame("alternating", x, er, ei, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        frame_t x = '{800, 0, 0, 0, 0, 0, 0, 0};
        frame_t er = '{default: 100};
        frame_t ei = '{default: 0};
        run_frame("backpressure", x, er, ei, 1, 1'b0);
    endtask

    task automatic test_reset_mid_compute();
        frame_t x = '{800, 0, 0, 0, 0, 0, 0, 0};
        frame_t dc = '{default: 800};
        frame_t er = '{800, 0, 0, 0, 0, 0, 0, 0};
        frame_t ei = '{default: 0};
        bit to;
        send_frame(x, to);
        repeat (5) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_busy_before: got %0b want 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: in_ready=%0b busy=%0b out_valid=%0b want 1/0/0", bus.in_ready, bus.busy, bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        run_frame("midreset_dc", dc, er, ei, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            frame_t x, er, ei;
            for (int i = 0; i < N; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
            model(x, er, ei);
            run_frame($sformatf("random%0d", f), x, er, ei, 2, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_alternating();
        test_backpressure();
        test_reset_mid_compute();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
